// File: rtl/muldiv_pkg.sv
// Shared constants, state encoding and operand-sign helpers for the RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned ITER_CNT  = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic a_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negation: out = neg ? -in : in.
module cond_negate #(
  parameter int unsigned Width = 32
) (
  input  logic             neg_i,
  input  logic [Width-1:0] in_i,
  output logic [Width-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + Width'(1)) : in_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (32-step shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN to complete all multiplies in a single cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] srca_i,
  input  logic [XLEN-1:0] srcb_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic            div_zero_o
);

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              busy_q, busy_d, done_q, done_d, div_zero_q, div_zero_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand magnitudes at accept time
  logic            sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;

  assign sa = a_signed(op_i) & srca_i[XLEN-1];
  assign sb = b_signed(op_i) & srcb_i[XLEN-1];

  cond_negate #(.Width(XLEN)) u_mag_a (.neg_i(sa), .in_i(srca_i), .out_o(mag_a));
  cond_negate #(.Width(XLEN)) u_mag_b (.neg_i(sb), .in_i(srcb_i), .out_o(mag_b));

  // Fast-path detection and result
  logic            div_by_zero, div_ovf, fast_mul, fast_go;
  logic [XLEN-1:0] fast_res;

  assign div_by_zero = is_div(op_i) && (srcb_i == '0);
  assign div_ovf     = is_div(op_i) && !op_i[0] && (srca_i == INT_MIN) && (srcb_i == '1);

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{sa}}, srca_i};
  assign fast_b    = {{XLEN{sb}}, srcb_i};
  assign fast_prod = fast_a * fast_b;
  assign fast_mul  = !is_div(op_i);
`else
  assign fast_mul  = 1'b0;
`endif

  assign fast_go = div_by_zero | div_ovf | fast_mul;

  always_comb begin
    fast_res = '0;
    if (div_by_zero) begin
      fast_res = op_i[1] ? srca_i : DIV0_QUOT;
    end else if (div_ovf) begin
      fast_res = op_i[1] ? '0 : INT_MIN;
    end
`ifdef MULDIV_FAST_MUL_EN
    else if (fast_mul) begin
      fast_res = (op_i == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One iteration step; acc holds {hi/rem, lo/multiplier/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, div_step, iter_next;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};
  assign div_ge   = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, b_q};
  assign div_rem  = acc_q[2*XLEN-2:XLEN-1] - b_q;
  assign div_step = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
  assign iter_next = is_div(op_q) ? div_step : mul_step;

  // Sign fix-up: divides place the selected quotient/remainder in the low half
  logic              fix_neg;
  logic [2*XLEN-1:0] fix_in, fix_out;
  logic [XLEN-1:0]   fix_res;

  assign fix_neg = (is_div(op_q) && op_q[1]) ? neg_a_q : (neg_a_q ^ neg_b_q);
  assign fix_in  = !is_div(op_q) ? iter_next :
                   op_q[1] ? {{XLEN{1'b0}}, iter_next[2*XLEN-1:XLEN]} :
                             {{XLEN{1'b0}}, iter_next[XLEN-1:0]};

  cond_negate #(.Width(2*XLEN)) u_fix (.neg_i(fix_neg), .in_i(fix_in), .out_o(fix_out));

  assign fix_res = ((op_q == OP_MUL) || is_div(op_q)) ? fix_out[XLEN-1:0] :
                                                         fix_out[2*XLEN-1:XLEN];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    b_d        = b_q;
    acc_d      = acc_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    result_d   = result_q;
    div_zero_d = div_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          neg_a_d = sa;
          neg_b_d = sb;
          b_d     = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          cnt_d   = '0;
          if (fast_go) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            result_d   = fast_res;
            div_zero_d = div_by_zero;
          end else begin
            state_d = ST_CALC;
            busy_d  = 1'b1;
          end
        end
      end
      ST_CALC: begin
        acc_d = iter_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_CNT - 1)) begin
          state_d    = ST_DONE;
          done_d     = 1'b1;
          result_d   = fix_res;
          div_zero_d = 1'b0;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      b_q        <= '0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = result_q;
  assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, fast paths, handshake and reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FM = 1'b1;
`else
  localparam bit FM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        busy, done, div_zero;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .srca_i     (srca),
    .srcb_i     (srcb),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .div_zero_o (div_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        dz;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Monitor: pops one expectation per done pulse
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_done: got done=1 with result 0x%08h, expected no done", result);
        end else begin
          e = q.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_div_zero"}, {31'b0, div_zero}, {31'b0, e.dz});
          check({e.name, "_latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
          check({e.name, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(q.size() == 0 && !busy && !done) && n < 200);
    if (n >= 200) begin
      n_total++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d, expected idle", busy, q.size());
    end
  endtask

  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res, input logic dz,
                       input bit fast, input bit push);
    exp_t e;
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    op    = o;
    srca  = a;
    srcb  = b;
    if (push) begin
      e.name = name;
      e.res  = res;
      e.dz   = dz;
      e.acc  = cyc + 1;
      e.lat  = fast ? 1 : 33;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, "_busy_after_accept"}, {31'b0, busy}, fast ? 32'd0 : 32'd1);
  endtask

  initial begin
    @(posedge clk);
    #2;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_div_zero", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("mul",    OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, FM, 1'b1);
    issue("mulhu",  OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, FM, 1'b1);
    issue("mulh",   OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, FM, 1'b1);
    issue("mulhsu", OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, FM, 1'b1);
    issue("div",    OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 1'b0, 1'b1);
    issue("rem",    OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    issue("divu",   OP_DIVU,   32'hFFFF_FFF9,  32'd2,         32'h7FFF_FFFC, 1'b0, 1'b0, 1'b1);
    issue("remu",   OP_REMU,   32'hFFFF_FFF9,  32'd2,         32'd1,         1'b0, 1'b0, 1'b1);
    issue("rem_z",  OP_REM,    32'd5,          32'd0,         32'd5,         1'b1, 1'b1, 1'b1);
    issue("div_ov", OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
    issue("rem_ov", OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0, 1'b1, 1'b1);

    // Start while busy must be dropped; only the first DIV completes
    issue("div_hs", OP_DIV,    32'd100,        32'd7,         32'd14,        1'b0, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op    = OP_DIVU;
    srca  = 32'd1;
    srcb  = 32'd1;
    @(posedge clk);
    #1;
    start = 1'b0;

    issue("divu_z", OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("result_hold", result, 32'hFFFF_FFFF);
    end

    // Async reset mid-divide clears all outputs immediately
    issue("divu_rst", OP_DIVU, 32'd1000,       32'd3,         32'd0,         1'b0, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    issue("mul_post", OP_MUL,  32'd3,          32'd4,         32'd12,        1'b0, FM, 1'b1);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
